// File: rtl/sram_burst_reader.sv
// Burst read initiator for the SRAM wrapper: issues one rd_req per row and streams rows out via a 2-entry buffer.
// Optional checking of command address and stray read data is enabled with `define SRAM_BURST_RD_ERR_CHK_EN.
module sram_burst_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] address,
  input  logic              rd_data_val,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued_r;
  logic [LEN_W-1:0]  popped_r;
  logic              pend_r;
  logic [1:0]        occ_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [DATA_W-1:0] buf_r [2];

  logic accept_s;
  logic pop_s;
  logic wr_s;
  logic rd_req_s;
  logic bad_addr_s;

  assign accept_s = cmd_valid && (state_r == IDLE);
  assign pop_s    = out_valid && out_ready;
  assign wr_s     = rd_data_val && pend_r;

  // A same-cycle pop frees a slot, which is what allows one row per cycle through only two entries.
  assign rd_req_s = (state_r == READ) && (issued_r != len_r) &&
                    ((3'(occ_r) + 3'(pend_r)) < (3'd2 + 3'(pop_s)));

`ifdef SRAM_BURST_RD_ERR_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  logic err_r;
  logic stray_s;

  assign bad_addr_s = ({1'b0, cmd_addr} >= DEPTH_C);
  assign stray_s    = rd_data_val && !pend_r;
  assign err        = err_r;

  // Sticky error: out-of-range command or read data with no request outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((accept_s && bad_addr_s) || stray_s) begin
      err_r <= 1'b1;
    end
  end
`else
  assign bad_addr_s = 1'b0;
  assign err        = 1'b0;
`endif

  assign cmd_ready = (state_r == IDLE);
  assign done      = (state_r == DONE);
  assign rd_req    = rd_req_s;
  assign mem_en    = rd_req_s;
  assign address   = addr_r;
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = buf_r[rd_ptr_r];
  assign out_last  = out_valid && (popped_r == (len_r - LEN_W'(1)));

  // Burst control FSM with address, issue and pop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      len_r    <= '0;
      issued_r <= '0;
      popped_r <= '0;
      pend_r   <= 1'b0;
    end else begin
      pend_r <= rd_req_s;
      if (pop_s) begin
        popped_r <= popped_r + LEN_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r   <= cmd_addr;
            len_r    <= cmd_len;
            issued_r <= '0;
            popped_r <= '0;
            if ((cmd_len == LEN_W'(0)) || bad_addr_s) begin
              state_r <= DONE;
            end else begin
              state_r <= READ;
            end
          end
        end
        READ: begin
          if (rd_req_s) begin
            addr_r   <= (addr_r == LAST_ADDR) ? ADDR_W'(0) : addr_r + ADDR_W'(1);
            issued_r <= issued_r + LEN_W'(1);
            if (issued_r == (len_r - LEN_W'(1))) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_s && (popped_r == (len_r - LEN_W'(1)))) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Two-entry row buffer; write and pop in the same cycle are both applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r[0] <= '0;
      buf_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (wr_s) begin
        buf_r[wr_ptr_r] <= rd_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + 2'(wr_s) - 2'(pop_s);
    end
  end

endmodule
